// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: pops bytes from the FIFO head and shifts them out as
// start / data (LSB first) / optional parity / stop frames on a single line.
`timescale 1ns/1ps

module fifo_serial_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned PARITY    = 0,   // 0 = none, 1 = even, 2 = odd
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     d,
    input  logic                 d_valid,
    output logic                 d_take,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic                 tx,
    output logic                 busy
);

    localparam int unsigned BIT_CNT_W = $clog2(WIDTH + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WIDTH);
    localparam logic PAR_EN  = (PARITY != 0);
    localparam logic PAR_ODD = (PARITY == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t                 state;
    logic [WIDTH-1:0]       shift;
    logic [DIV_WIDTH-1:0]   n;
    logic [DIV_WIDTH-1:0]   div_cnt;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   par;

    logic [DIV_WIDTH-1:0]   div_n_c;
    logic                   bit_end_c;
    logic                   load_now_c;

    // Effective divisor (0 behaves as 1), end-of-bit detect and load decision.
    // d_valid is ignored while d_take is still high so the head is never popped twice.
    // n is always >= 1 once loaded, so n - 1 cannot underflow and the full
    // 2^DIV_WIDTH-1 range counts without overflow.
    always_comb begin
        div_n_c    = (divisor == '0) ? DIV_WIDTH'(1) : divisor;
        bit_end_c  = (div_cnt == (n - DIV_WIDTH'(1)));
        load_now_c = d_valid && !d_take &&
                     ((state == IDLE) || ((state == STOP) && bit_end_c));
    end

    // Frame sequencer with registered tx / busy / d_take.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            d_take  <= 1'b0;
            shift   <= '0;
            n       <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
        end else begin
            d_take <= 1'b0;
            if (load_now_c) begin
                // Latch byte, parity and bit period; start bit goes out immediately.
                shift   <= d;
                par     <= (^d) ^ PAR_ODD;
                n       <= div_n_c;
                div_cnt <= '0;
                bit_cnt <= '0;
                state   <= START;
                tx      <= 1'b0;
                busy    <= 1'b1;
                d_take  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        tx   <= 1'b1;
                        busy <= 1'b0;
                    end
                    START: begin
                        if (bit_end_c) begin
                            div_cnt <= '0;
                            state   <= DATA;
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                            bit_cnt <= BIT_CNT_W'(1);
                        end else begin
                            div_cnt <= div_cnt + DIV_WIDTH'(1);
                        end
                    end
                    DATA: begin
                        if (bit_end_c) begin
                            div_cnt <= '0;
                            if (bit_cnt == LAST_BIT) begin
                                if (PAR_EN) begin
                                    state <= PAR;
                                    tx    <= par;
                                end else begin
                                    state <= STOP;
                                    tx    <= 1'b1;
                                end
                            end else begin
                                tx      <= shift[0];
                                shift   <= shift >> 1;
                                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                            end
                        end else begin
                            div_cnt <= div_cnt + DIV_WIDTH'(1);
                        end
                    end
                    PAR: begin
                        if (bit_end_c) begin
                            div_cnt <= '0;
                            state   <= STOP;
                            tx      <= 1'b1;
                        end else begin
                            div_cnt <= div_cnt + DIV_WIDTH'(1);
                        end
                    end
                    STOP: begin
                        // A back-to-back load is handled above; here the line goes idle.
                        if (bit_end_c) begin
                            div_cnt <= '0;
                            state   <= IDLE;
                            tx      <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            div_cnt <= div_cnt + DIV_WIDTH'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
